// File: rtl/sys_cmd_decoder_if.sv
// Bus bundle around the command decoder: rx byte stream, reg-file port, ALU port and tx response link.
interface sys_cmd_decoder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0]   rx_data;
  logic                rx_valid;
  logic [ADDR_W-1:0]   rf_addr;
  logic                rf_wr_en;
  logic [DATA_W-1:0]   rf_wr_data;
  logic                rf_rd_en;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_valid;
  logic                alu_en;
  logic [3:0]          alu_fun;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_valid;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                cmd_err;
  logic                rx_overrun;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_data, tx_valid,
           cmd_err, rx_overrun
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_data, tx_valid,
           cmd_err, rx_overrun
  );
endinterface

// File: rtl/sys_cmd_decoder.sv
// Parses command frames from the synchronised rx byte stream into reg-file / ALU strobes
// and returns read/ALU results as bytes on a valid/ready tx link. All outputs registered.
module sys_cmd_decoder #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
  parameter int                OPA_ADDR    = 0,
  parameter int                OPB_ADDR    = 1
) (
  input logic              clk,
  input logic              rst,
  sys_cmd_decoder_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   hi_q, hi_n;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_n;
  logic [DATA_W-1:0]   wr_data_q, wr_data_n;
  logic [3:0]          fun_q, fun_n;
  logic [DATA_W-1:0]   tx_data_q, tx_data_n;
  logic                tx_valid_q, tx_valid_n;
  logic                wr_en_q, wr_en_n, rd_en_q, rd_en_n, alu_en_q, alu_en_n;
  logic                cmd_err_q, cmd_err_n, ovr_q, ovr_n;
  logic                accepting, tx_acc;

  assign tx_acc = tx_valid_q & bus.tx_ready;
  assign accepting = (state == IDLE) || (state == WR_ADDR) || (state == WR_DATA) ||
                     (state == RD_ADDR) || (state == ALU_A) || (state == ALU_B) || (state == ALU_FUN);

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    hi_n       = hi_q;
    rf_addr_n  = rf_addr_q;
    wr_data_n  = wr_data_q;
    fun_n      = fun_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    alu_en_n   = 1'b0;
    cmd_err_n  = 1'b0;
    ovr_n      = bus.rx_valid & ~accepting;
    case (state)
      IDLE: if (bus.rx_valid) begin
        if      (bus.rx_data == CMD_WR)      state_n = WR_ADDR;
        else if (bus.rx_data == CMD_RD)      state_n = RD_ADDR;
        else if (bus.rx_data == CMD_ALU_OP)  state_n = ALU_A;
        else if (bus.rx_data == CMD_ALU_NOP) state_n = ALU_FUN;
        else                                 cmd_err_n = 1'b1;
      end
      WR_ADDR: if (bus.rx_valid) begin
        addr_n  = bus.rx_data[ADDR_W-1:0];
        state_n = WR_DATA;
      end
      WR_DATA: if (bus.rx_valid) begin
        wr_en_n   = 1'b1;
        rf_addr_n = addr_q;
        wr_data_n = bus.rx_data;
        state_n   = IDLE;
      end
      RD_ADDR: if (bus.rx_valid) begin
        rd_en_n   = 1'b1;
        rf_addr_n = bus.rx_data[ADDR_W-1:0];
        state_n   = RD_WAIT;
      end
      RD_WAIT: if (bus.rf_rd_valid) begin
        tx_data_n  = bus.rf_rd_data;
        tx_valid_n = 1'b1;
        state_n    = TX_RD;
      end
      ALU_A: if (bus.rx_valid) begin
        wr_en_n   = 1'b1;
        rf_addr_n = ADDR_W'(OPA_ADDR);
        wr_data_n = bus.rx_data;
        state_n   = ALU_B;
      end
      ALU_B: if (bus.rx_valid) begin
        wr_en_n   = 1'b1;
        rf_addr_n = ADDR_W'(OPB_ADDR);
        wr_data_n = bus.rx_data;
        state_n   = ALU_FUN;
      end
      ALU_FUN: if (bus.rx_valid) begin
        alu_en_n = 1'b1;
        fun_n    = bus.rx_data[3:0];
        state_n  = ALU_WAIT;
      end
      // Low byte goes out first; high byte is parked until the low byte is taken.
      ALU_WAIT: if (bus.alu_valid) begin
        tx_data_n  = bus.alu_out[DATA_W-1:0];
        hi_n       = bus.alu_out[2*DATA_W-1:DATA_W];
        tx_valid_n = 1'b1;
        state_n    = TX_LO;
      end
      TX_RD, TX_HI: if (tx_acc) begin
        tx_valid_n = 1'b0;
        state_n    = IDLE;
      end
      TX_LO: if (tx_acc) begin
        tx_data_n = hi_q;
        state_n   = TX_HI;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      hi_q       <= '0;
      rf_addr_q  <= '0;
      wr_data_q  <= '0;
      fun_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      hi_q       <= hi_n;
      rf_addr_q  <= rf_addr_n;
      wr_data_q  <= wr_data_n;
      fun_q      <= fun_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      wr_en_q    <= wr_en_n;
      rd_en_q    <= rd_en_n;
      alu_en_q   <= alu_en_n;
      cmd_err_q  <= cmd_err_n;
      ovr_q      <= ovr_n;
    end
  end

  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.rf_rd_en   = rd_en_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_fun    = fun_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.cmd_err    = cmd_err_q;
  assign bus.rx_overrun = ovr_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed frames into sys_cmd_decoder; expected strobes/responses queued and checked by a monitor.
module tb_sys_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_cmd_decoder_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  sys_cmd_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_err = 0, n_cerr = 0, n_ovr = 0;
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mem [16];
  int rd_lat = 2, alu_lat = 3;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_fun.size() == 0 && exp_tx.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(i >= 300), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(string name);
    chk(name, {bus.rf_addr, bus.rf_wr_en, bus.rf_wr_data, bus.rf_rd_en, bus.alu_en, bus.alu_fun,
               bus.tx_data, bus.tx_valid, bus.cmd_err, bus.rx_overrun}, 32'd0);
  endtask

  // Reg-file responder: mirrors writes, answers reads after rd_lat cycles.
  initial begin
    int cnt = 0;
    logic [3:0] ra = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    bus.rf_rd_valid = 1'b0; bus.rf_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.rf_rd_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin bus.rf_rd_valid = 1'b1; bus.rf_rd_data = mem[ra]; end
      end
      if (!rst && bus.rf_wr_en) mem[bus.rf_addr] = bus.rf_wr_data;
      if (!rst && bus.rf_rd_en) begin cnt = rd_lat; ra = bus.rf_addr; end
    end
  end

  // ALU responder: fun 0 = add, otherwise multiply.
  initial begin
    int cnt = 0;
    logic [3:0] f = '0;
    bus.alu_valid = 1'b0; bus.alu_out = '0;
    forever begin
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.alu_valid = 1'b1;
          bus.alu_out = (f == 4'd0) ? 16'(mem[0]) + 16'(mem[1]) : 16'(mem[0]) * 16'(mem[1]);
        end
      end
      if (!rst && bus.alu_en) begin cnt = alu_lat; f = bus.alu_fun; end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or a tx transfer.
  initial begin
    logic hold = 1'b0;
    logic [7:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin hold = 1'b0; continue; end
      if (hold) begin
        chk("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
        chk("tx_data_stable", 32'(bus.tx_data), 32'(held));
      end
      hold = bus.tx_valid & ~bus.tx_ready;
      held = bus.tx_data;
      if (bus.rf_wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", {bus.rf_addr, bus.rf_wr_data}, 32'hFFFFFFFF);
        else chk("rf_write", 32'({bus.rf_addr, bus.rf_wr_data}), 32'(exp_wr.pop_front()));
      end
      if (bus.rf_rd_en) begin
        if (exp_rd.size() == 0) chk("unexpected_rd", 32'(bus.rf_addr), 32'hFFFFFFFF);
        else chk("rf_read_addr", 32'(bus.rf_addr), 32'(exp_rd.pop_front()));
      end
      if (bus.alu_en) begin
        if (exp_fun.size() == 0) chk("unexpected_alu", 32'(bus.alu_fun), 32'hFFFFFFFF);
        else chk("alu_fun", 32'(bus.alu_fun), 32'(exp_fun.pop_front()));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) chk("unexpected_tx", 32'(bus.tx_data), 32'hFFFFFFFF);
        else chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.cmd_err) n_cerr++;
      if (bus.rx_overrun) n_ovr++;
    end
  end

  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: write 3C to addr 5, no response
    exp_wr.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    drain();

    // 2: read addr 5 back
    exp_rd.push_back(4'h5); exp_tx.push_back(8'h3C);
    send(8'hBB); send(8'h05);
    drain();

    // 3: 0A * 03 = 001E
    exp_wr.push_back({4'h0, 8'h0A}); exp_wr.push_back({4'h1, 8'h03});
    exp_fun.push_back(4'h2); exp_tx.push_back(8'h1E); exp_tx.push_back(8'h00);
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
    drain();

    // 4: same op with tx_ready held low 10 cycles in TX_LO
    exp_wr.push_back({4'h0, 8'h0A}); exp_wr.push_back({4'h1, 8'h03});
    exp_fun.push_back(4'h2); exp_tx.push_back(8'h1E); exp_tx.push_back(8'h00);
    bus.tx_ready = 1'b0;
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
    begin
      int i;
      for (i = 0; i < 100 && !bus.tx_valid; i++) begin @(posedge clk); #1; end
      chk("tx_valid_timeout", 32'(i >= 100), 32'd0);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("tx_lo_held", 32'({bus.tx_valid, bus.tx_data}), 32'h11E);
    bus.tx_ready = 1'b1;
    drain();

    // ALU_NOP add on stored operands: 0A + 03 = 000D
    exp_fun.push_back(4'h0); exp_tx.push_back(8'h0D); exp_tx.push_back(8'h00);
    send(8'hDD); send(8'h00);
    drain();

    // FF * FF = FE01, both result bytes nonzero
    exp_wr.push_back({4'h0, 8'hFF}); exp_wr.push_back({4'h1, 8'hFF});
    exp_fun.push_back(4'h2); exp_tx.push_back(8'h01); exp_tx.push_back(8'hFE);
    send(8'hCC); send(8'hFF); send(8'hFF); send(8'h02);
    drain();

    // 5: unknown command, then a read is still served
    send(8'h55);
    exp_rd.push_back(4'h2); exp_tx.push_back(8'h12);
    send(8'hBB); send(8'h02);
    drain();

    // Byte during RD_WAIT is dropped with rx_overrun
    rd_lat = 5;
    exp_rd.push_back(4'h3); exp_tx.push_back(8'h13);
    send(8'hBB); send(8'h03); send(8'hAA);
    drain();
    rd_lat = 2;
    exp_wr.push_back({4'h6, 8'h77}); exp_rd.push_back(4'h6); exp_tx.push_back(8'h77);
    send(8'hAA); send(8'h06); send(8'h77); send(8'hBB); send(8'h06);
    drain();

    // 6: reset mid-frame aborts it
    send(8'hAA); send(8'h07);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midframe_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wr.push_back({4'h1, 8'hFF}); exp_rd.push_back(4'h1); exp_tx.push_back(8'hFF);
    send(8'hAA); send(8'h01); send(8'hFF); send(8'hBB); send(8'h01);
    drain();

    chk("cmd_err_pulses", 32'(n_cerr), 32'd1);
    chk("rx_overrun_pulses", 32'(n_ovr), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
